// File: rtl/mips_mul_pkg.sv
// Shared constants and state encoding for the HI/LO multiply control stage.
package mips_mul_pkg;

    localparam int WORD_W          = 32;
    localparam int DWORD_W         = 64;
    localparam int LATENCY_DEFAULT = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/mul_sign_fix.sv
// Sign handling around the unsigned multiplier: operand magnitudes and the
// result-negate flag on the way in, conditional 64-bit negate on the way out.
module mul_sign_fix
    import mips_mul_pkg::*;
(
    input  logic               is_signed,
    input  logic [WORD_W-1:0]  rs_val,
    input  logic [WORD_W-1:0]  rt_val,
    input  logic               neg_in,
    input  logic [DWORD_W-1:0] product,
    output logic [WORD_W-1:0]  abs_a,
    output logic [WORD_W-1:0]  abs_b,
    output logic               neg_out,
    output logic [DWORD_W-1:0] result
);

    // |0x80000000| stays 0x80000000, which is correct when read as unsigned.
    assign abs_a   = (is_signed && rs_val[WORD_W-1]) ? (~rs_val + WORD_W'(1)) : rs_val;
    assign abs_b   = (is_signed && rt_val[WORD_W-1]) ? (~rt_val + WORD_W'(1)) : rt_val;
    assign neg_out = is_signed & (rs_val[WORD_W-1] ^ rt_val[WORD_W-1]);

    // Wraps modulo 2^64, so a zero product stays zero.
    assign result  = neg_in ? (~product + DWORD_W'(1)) : product;

endmodule

// File: rtl/hilo_mul_unit.sv
// MULT/MULTU sequencer and HI/LO register file around an external 32x32->64
// combinational multiplier treated as a LATENCY-cycle multicycle path.
module hilo_mul_unit
    import mips_mul_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEFAULT,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WORD_W-1:0]  rs_val,
    input  logic [WORD_W-1:0]  rt_val,
    input  logic               mfhi,
    input  logic               mflo,
    input  logic               mthi,
    input  logic               mtlo,
    input  logic [WORD_W-1:0]  mt_data,
    output logic [WORD_W-1:0]  mul_a,
    output logic [WORD_W-1:0]  mul_b,
    input  logic [DWORD_W-1:0] mul_product,
    output logic               busy,
    output logic               stall,
    output logic [WORD_W-1:0]  rd_data,
    output logic [WORD_W-1:0]  hi,
    output logic [WORD_W-1:0]  lo
);

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               neg, neg_d;
    logic [WORD_W-1:0]  mul_a_d, mul_b_d, hi_d, lo_d;

    logic [WORD_W-1:0]  abs_a, abs_b;
    logic               neg_in;
    logic [DWORD_W-1:0] fixed_product;

    mul_sign_fix u_sign_fix (
        .is_signed (is_signed),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .neg_in    (neg),
        .product   (mul_product),
        .abs_a     (abs_a),
        .abs_b     (abs_b),
        .neg_out   (neg_in),
        .result    (fixed_product)
    );

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path through the case infers a latch.
        state_d = state;
        cnt_d   = cnt;
        neg_d   = neg;
        mul_a_d = mul_a;
        mul_b_d = mul_b;
        hi_d    = hi;
        lo_d    = lo;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    // start takes priority; a concurrent MTHI/MTLO is dropped.
                    mul_a_d = abs_a;
                    mul_b_d = abs_b;
                    neg_d   = neg_in;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = ST_BUSY;
                end else begin
                    if (mthi) hi_d = mt_data;
                    if (mtlo) lo_d = mt_data;
                end
            end
            ST_BUSY: begin
                if (cnt != '0) begin
                    cnt_d = cnt - CNT_W'(1);
                end else begin
                    {hi_d, lo_d} = fixed_product;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            neg   <= 1'b0;
            mul_a <= '0;
            mul_b <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            neg   <= neg_d;
            mul_a <= mul_a_d;
            mul_b <= mul_b_d;
            hi    <= hi_d;
            lo    <= lo_d;
        end
    end

    assign busy    = (state == ST_BUSY);
    assign stall   = busy & (start | mfhi | mflo | mthi | mtlo);
    assign rd_data = mfhi ? hi : lo;

endmodule

// File: tb/tb_hilo_mul_unit.sv
// Directed bench for hilo_mul_unit with a behavioural stand-in for the
// external unsigned 32x32->64 multiplier.
module tb_hilo_mul_unit;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, is_signed, mfhi, mflo, mthi, mtlo;
    logic [31:0] rs_val, rt_val, mt_data;
    logic [31:0] mul_a, mul_b, rd_data, hi, lo;
    logic [63:0] mul_product;
    logic        busy, stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mul_product = {32'h0, mul_a} * {32'h0, mul_b};

    hilo_mul_unit #(.LATENCY(LAT), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .mfhi        (mfhi),
        .mflo        (mflo),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .mt_data     (mt_data),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_product (mul_product),
        .busy        (busy),
        .stall       (stall),
        .rd_data     (rd_data),
        .hi          (hi),
        .lo          (lo)
    );

    task automatic idle_inputs();
        start = 0; is_signed = 0; mfhi = 0; mflo = 0; mthi = 0; mtlo = 0;
        rs_val = '0; rt_val = '0; mt_data = '0;
    endtask

    // Issue one multiply, count busy cycles (bounded), return HI/LO afterwards.
    task automatic run_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output int n, output logic [31:0] h, output logic [31:0] l);
        @(negedge clk);
        start = 1; is_signed = sgn; rs_val = a; rt_val = b;
        @(negedge clk);
        idle_inputs();
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        h = hi;
        l = lo;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo got=%h exp=0", {hi, lo}); end
        checks++; if ({mul_a, mul_b} !== 64'h0) begin errors++; $display("FAIL reset_ops got=%h exp=0", {mul_a, mul_b}); end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        int n; logic [31:0] h, l;
        run_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n, h, l);
        checks++; if (n !== LAT) begin errors++; $display("FAIL multu_busy_cycles got=%0d exp=%0d", n, LAT); end
        checks++; if ({h, l} !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL multu_max got=%h exp=fffffffe00000001", {h, l}); end
        run_mul(1'b0, 32'h8000_0000, 32'h0000_0002, n, h, l);
        checks++; if ({h, l} !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL multu_carry got=%h exp=0000000100000000", {h, l}); end
    endtask

    task automatic test_signed();
        int n; logic [31:0] h, l;
        run_mul(1'b1, 32'hFFFF_FFFD, 32'h0000_0005, n, h, l);
        checks++; if ({h, l} !== 64'hFFFF_FFFF_FFFF_FFF1) begin errors++; $display("FAIL mult_neg3x5 got=%h exp=fffffffffffffff1", {h, l}); end
        run_mul(1'b1, 32'h8000_0000, 32'h8000_0000, n, h, l);
        checks++; if ({h, l} !== 64'h4000_0000_0000_0000) begin errors++; $display("FAIL mult_minmin got=%h exp=4000000000000000", {h, l}); end
        run_mul(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, n, h, l);
        checks++; if ({h, l} !== 64'h0000_0000_0000_000E) begin errors++; $display("FAIL mult_neg7xneg2 got=%h exp=000000000000000e", {h, l}); end
        run_mul(1'b1, 32'hD555_2AAA, 32'h0000_0000, n, h, l);
        checks++; if ({h, l} !== 64'h0) begin errors++; $display("FAIL mult_negzero got=%h exp=0", {h, l}); end
    endtask

    task automatic test_mflo_stall();
        int n;
        @(negedge clk);
        start = 1; is_signed = 0; rs_val = 32'd3; rt_val = 32'd4;
        @(negedge clk);
        idle_inputs();
        mflo = 1;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            if (stall !== 1'b1) begin errors++; $display("FAIL mflo_stall_high got=%b exp=1 cycle=%0d", stall, n); end
            checks++;
            n++;
            @(negedge clk);
        end
        checks++; if (n !== LAT) begin errors++; $display("FAIL mflo_stall_cycles got=%0d exp=%0d", n, LAT); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mflo_stall_release got=%b exp=0", stall); end
        checks++; if (rd_data !== 32'd12) begin errors++; $display("FAIL mflo_data got=%h exp=0000000c", rd_data); end
        idle_inputs();
    endtask

    task automatic test_mt_and_reads();
        int n;
        @(negedge clk);
        mthi = 1; mt_data = 32'h1234_5678;
        @(negedge clk);
        idle_inputs(); mfhi = 1;
        #1;
        checks++; if (rd_data !== 32'h1234_5678) begin errors++; $display("FAIL mthi_mfhi got=%h exp=12345678", rd_data); end
        @(negedge clk);
        idle_inputs(); mthi = 1; mtlo = 1; mt_data = 32'hCAFE_0001;
        @(negedge clk);
        idle_inputs(); mfhi = 1; mflo = 1;
        #1;
        checks++; if ({hi, lo} !== {2{32'hCAFE_0001}}) begin errors++; $display("FAIL mt_both got=%h exp=cafe0001cafe0001", {hi, lo}); end
        checks++; if (rd_data !== hi) begin errors++; $display("FAIL mfhi_priority got=%h exp=%h", rd_data, hi); end
        // start with mthi (write dropped) and mfhi (reads the old HI this cycle)
        @(negedge clk);
        idle_inputs();
        start = 1; is_signed = 0; rs_val = 32'd6; rt_val = 32'd7;
        mthi = 1; mfhi = 1; mt_data = 32'h1234_5678;
        #1;
        checks++; if (rd_data !== 32'hCAFE_0001) begin errors++; $display("FAIL start_mfhi_old got=%h exp=cafe0001", rd_data); end
        @(negedge clk);
        idle_inputs();
        n = 0;
        while (busy === 1'b1 && n < 20) begin n++; @(negedge clk); end
        checks++; if ({hi, lo} !== 64'd42) begin errors++; $display("FAIL start_beats_mthi got=%h exp=000000000000002a", {hi, lo}); end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        start = 1; is_signed = 0; rs_val = 32'd10; rt_val = 32'd10;
        @(negedge clk);
        idle_inputs();
        repeat (LAT - 1) @(negedge clk);
        // now in the last BUSY cycle (cnt == 0): new start must stall
        start = 1; is_signed = 1; rs_val = 32'hFFFF_FFFF; rt_val = 32'd9;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL last_busy_stall got=%b exp=1", stall); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL last_busy_not_accepted got=%b exp=0", busy); end
        checks++; if ({hi, lo} !== 64'd100) begin errors++; $display("FAIL b2b_first got=%h exp=0000000000000064", {hi, lo}); end
        @(negedge clk);
        idle_inputs();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got=%b exp=1", busy); end
        n = 0;
        while (busy === 1'b1 && n < 20) begin n++; @(negedge clk); end
        checks++; if (n !== LAT) begin errors++; $display("FAIL b2b_busy_cycles got=%0d exp=%0d", n, LAT); end
        checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF7) begin errors++; $display("FAIL b2b_second got=%h exp=fffffffffffffff7", {hi, lo}); end
    endtask

    task automatic test_reset_mid_busy();
        int n; logic [31:0] h, l;
        @(negedge clk);
        mthi = 1; mtlo = 1; mt_data = 32'h5555_AAAA;
        @(negedge clk);
        idle_inputs();
        start = 1; rs_val = 32'h0001_0000; rt_val = 32'h0001_0000;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        // cnt is now 2
        rst = 1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL rst_mid_hilo got=%h exp=0", {hi, lo}); end
        @(negedge clk);
        rst = 0;
        run_mul(1'b0, 32'h0001_0000, 32'h0001_0000, n, h, l);
        checks++; if (n !== LAT) begin errors++; $display("FAIL rst_rerun_cycles got=%0d exp=%0d", n, LAT); end
        checks++; if ({h, l} !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL rst_rerun_result got=%h exp=0000000100000000", {h, l}); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_mflo_stall();
        test_mt_and_reads();
        test_back_to_back();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
